// File: rtl/clocked_video_rx_pkg.sv
// Shared types for the clocked-video receiver: FSM states, FIFO word layout and
// the VIP packet-type code.
package clocked_video_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam int VIP_DATA_W = 24;

  // Field order matches the flat {data, sop, eop} word stored in stream_fifo.
  typedef struct packed {
    logic [VIP_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } fifo_entry_t;

  localparam logic [3:0] VIP_TYPE_VIDEO = 4'h0;

endpackage

// File: rtl/clocked_video_rx_fifo.sv
// Synchronous show-ahead FIFO; a written word appears on pop_data_o the next cycle.
// Pushes while full and pops while empty are ignored.
module stream_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/clocked_video_rx.sv
// Clocked-video to Avalon-ST video receiver: frames active pixels into packets
// (header word, pixels, eop on the last pixel) through a show-ahead output FIFO.
module clocked_video_rx
  import clocked_video_rx_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_v,
  input  logic              vid_h,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_startofpacket,
  output logic              dout_endofpacket,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  // state    | meaning
  // IDLE     | after reset or a skipped frame; wait for vblank
  // WAIT_SOF | in vblank; wait for the active region
  // ACTIVE   | packing pixels, one pixel held back to tag eop
  // FLUSH    | write the held pixel with eop

  localparam int WORD_W = DATA_W + 2;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic                accept;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   fifo_rd;
  logic                fifo_empty, fifo_full;
  logic [DATA_W-1:0]   header_data;

  assign accept      = vid_datavalid & ~vid_v & ~vid_h;
  assign header_data = {{(DATA_W-4){1'b0}}, VIP_TYPE_VIDEO};

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    push          = 1'b0;
    push_word     = '0;
    case (state_q)
      IDLE: begin
        if (vid_v) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!vid_v) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (vid_v) begin
          state_d = hold_vld_q ? FLUSH : WAIT_SOF;
        end else if (accept) begin
          if (!hold_vld_q) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
              state_d    = IDLE;
            end else begin
              push       = 1'b1;
              push_word  = {header_data, 1'b1, 1'b0};
              overflow_d = 1'b0;
              hold_d     = vid_data;
              hold_vld_d = 1'b1;
            end
          end else begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              push      = 1'b1;
              push_word = {hold_q, 1'b0, 1'b0};
            end
            hold_d = vid_data;
          end
        end
      end
      FLUSH: begin
        if (accept) overflow_d = 1'b1;
        if (!fifo_full) begin
          push          = 1'b1;
          push_word     = {hold_q, 1'b0, 1'b1};
          frame_count_d = frame_count_q + 16'd1;
          hold_d        = '0;
          hold_vld_d    = 1'b0;
          state_d       = WAIT_SOF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  stream_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_clk),
    .rst_i       (reset_reset),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (dout_valid & dout_ready),
    .pop_data_o  (fifo_rd),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Stale memory contents are masked so an empty FIFO presents all zeros.
  assign dout_valid = ~fifo_empty;
  assign {dout_data, dout_startofpacket, dout_endofpacket} = fifo_empty ? '0 : fifo_rd;

  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_clocked_video_rx.sv
// Scoreboard bench for clocked_video_rx: directed frames push expected words,
// a negedge monitor pops and compares every accepted dout word.
module tb_clocked_video_rx;
  import clocked_video_rx_pkg::*;

  localparam int DW = 24;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic [DW-1:0] vid_data;
  logic          vid_datavalid, vid_v, vid_h;
  logic [DW-1:0] dout_data;
  logic          dout_valid, dout_ready, dout_startofpacket, dout_endofpacket;
  logic          overflow;
  logic [15:0]   frame_count;

  always #5 clk_clk = ~clk_clk;

  clocked_video_rx #(.DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .clk_clk            (clk_clk),
    .reset_reset        (reset_reset),
    .vid_data           (vid_data),
    .vid_datavalid      (vid_datavalid),
    .vid_v              (vid_v),
    .vid_h              (vid_h),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .overflow           (overflow),
    .frame_count        (frame_count)
  );

  fifo_entry_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int pix_sent = 0;
  bit sb_en = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk_clk) begin
    if (!reset_reset && sb_en && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b expected none",
                 dout_data, dout_startofpacket, dout_endofpacket);
      end else begin
        fifo_entry_t e;
        e = exp_q.pop_front();
        check("dout_word", {6'b0, dout_data, dout_startofpacket, dout_endofpacket},
              {6'b0, e.data, e.sop, e.eop});
      end
    end
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic push_exp(logic [DW-1:0] d, logic sop, logic eop);
    fifo_entry_t e;
    e.data = d;
    e.sop  = sop;
    e.eop  = eop;
    exp_q.push_back(e);
  endtask

  task automatic push_frame_exp(int w, int h, logic [DW-1:0] base);
    push_exp('0, 1'b1, 1'b0);
    for (int i = 1; i <= w * h; i++) push_exp(base + DW'(i), 1'b0, i == w * h);
  endtask

  task automatic drive_pixel(logic [DW-1:0] d);
    vid_h = 1'b0;
    vid_datavalid = 1'b1;
    vid_data = d;
    pix_sent++;
    step();
  endtask

  // Vblank, active lines with 2-cycle hblank, then back into vblank.
  task automatic send_frame(int w, int h, logic [DW-1:0] base);
    int idx = 0;
    vid_v = 1'b1; vid_h = 1'b1; vid_datavalid = 1'b0;
    repeat (3) step();
    vid_v = 1'b0;
    repeat (2) step();
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        idx++;
        drive_pixel(base + DW'(idx));
      end
      vid_h = 1'b1; vid_datavalid = 1'b0;
      repeat (2) step();
    end
    vid_v = 1'b1;
    step();
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_clk);
    check({name, "_valid_low"}, {31'b0, dout_valid}, 0);
  endtask

  initial begin
    reset_reset = 1'b1;
    vid_v = 1'b0; vid_h = 1'b0; vid_datavalid = 1'b0; vid_data = '0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    check("rst_valid", {31'b0, dout_valid}, 0);
    check("rst_sop", {31'b0, dout_startofpacket}, 0);
    check("rst_eop", {31'b0, dout_endofpacket}, 0);
    check("rst_data", {8'b0, dout_data}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_frame_count", {16'b0, frame_count}, 0);

    // Reset released mid-frame: pixels before the first vblank are ignored.
    step();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("post_rst_valid", {31'b0, dout_valid}, 0);
    check("post_rst_overflow", {31'b0, overflow}, 0);
    step();
    for (int i = 0; i < 6; i++) drive_pixel(24'hABC000 + DW'(i));
    vid_datavalid = 1'b0;
    repeat (4) step();
    check("midframe_valid", {31'b0, dout_valid}, 0);
    check("midframe_fc", {16'b0, frame_count}, 0);

    // 4x2 frame, sink always ready.
    push_frame_exp(4, 2, 24'h100000);
    send_frame(4, 2, 24'h100000);
    wait_drain("frame4x2", 50);
    check("frame4x2_fc", {16'b0, frame_count}, 1);
    check("frame4x2_ovf", {31'b0, overflow}, 0);

    // Zero-pixel frame.
    send_frame(0, 0, '0);
    repeat (5) step();
    check("zero_valid", {31'b0, dout_valid}, 0);
    check("zero_fc", {16'b0, frame_count}, 1);

    // 20-pixel line with a stalled sink: header + p1..p15 fit, p16..p19 drop.
    dout_ready = 1'b0;
    push_exp('0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) push_exp(24'h200000 + DW'(i), 1'b0, 1'b0);
    push_exp(24'h200000 + DW'(20), 1'b0, 1'b1);
    pix_sent = 0;
    fork
      send_frame(20, 1, 24'h200000);
      begin
        wait (pix_sent == 17);
        @(negedge clk_clk);
        check("ovf_before_p17", {31'b0, overflow}, 0);
        @(negedge clk_clk);
        check("ovf_after_p17", {31'b0, overflow}, 1);
      end
    join
    repeat (4) step();
    check("stall_valid", {31'b0, dout_valid}, 1);
    check("stall_fc", {16'b0, frame_count}, 1);
    dout_ready = 1'b1;
    wait_drain("overflow", 100);
    check("overflow_fc", {16'b0, frame_count}, 2);
    check("overflow_sticky", {31'b0, overflow}, 1);

    // Reset pulsed mid-packet; partial packet discarded.
    sb_en = 1'b0;
    vid_v = 1'b1; vid_h = 1'b1; vid_datavalid = 1'b0;
    repeat (3) step();
    vid_v = 1'b0;
    repeat (2) step();
    for (int i = 1; i <= 5; i++) drive_pixel(24'h300000 + DW'(i));
    vid_datavalid = 1'b0;
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("rst_mid_valid", {31'b0, dout_valid}, 0);
    check("rst_mid_fc", {16'b0, frame_count}, 0);
    exp_q.delete();
    sb_en = 1'b1;
    step();
    for (int i = 6; i <= 8; i++) drive_pixel(24'h300000 + DW'(i));
    vid_datavalid = 1'b0;
    step();
    push_frame_exp(4, 2, 24'h400000);
    send_frame(4, 2, 24'h400000);
    wait_drain("after_rst", 50);
    check("after_rst_fc", {16'b0, frame_count}, 1);

    // frame_count wrap.
    force dut.frame_count_q = 16'hFFFF;
    repeat (2) step();
    release dut.frame_count_q;
    step();
    check("fc_preload", {16'b0, frame_count}, 32'h0000FFFF);
    push_frame_exp(2, 1, 24'h500000);
    send_frame(2, 1, 24'h500000);
    wait_drain("wrap", 50);
    check("fc_wrap", {16'b0, frame_count}, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
